// File: rtl/wasm_pkg.sv
// Shared encodings for the WASM operand-stack engine and its memory port.
package wasm_pkg;

    typedef enum logic [1:0] {
        STK_PUSH = 2'd0,
        STK_POP  = 2'd1,
        STK_PEEK = 2'd2,
        STK_DROP = 2'd3
    } stk_op_e;

    typedef enum logic [1:0] {
        STK_OK     = 2'd0,
        STK_OVF    = 2'd1,
        STK_UDF    = 2'd2,
        STK_BADCNT = 2'd3
    } stk_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WR_BYTE,
        S_RD_BYTE,
        S_WAIT_IDLE,
        S_RESPOND
    } stk_state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_BUSY,
        P_DROP
    } port_state_e;

endpackage

// File: rtl/wasm_operand_stack_if.sv
// Command/response bundle of the stack engine and the byte-wide memory bus.
interface wasm_stk_if #(
    parameter int VALUE_W = 64,
    parameter int DEPTH   = 64,
    parameter int MAX_POP = 2
);
    localparam int CW = $clog2(MAX_POP + 1);
    localparam int DW = $clog2(DEPTH + 1);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [CW-1:0]              cmd_count;
    logic                       cmd_wide;
    logic [VALUE_W-1:0]         cmd_value;
    logic                       rsp_valid;
    logic                       rsp_error;
    logic [1:0]                 rsp_code;
    logic [MAX_POP*VALUE_W-1:0] rsp_values;
    logic [DW-1:0]              depth;

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_wide, cmd_value,
        output cmd_ready, rsp_valid, rsp_error, rsp_code, rsp_values, depth
    );

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_wide, cmd_value,
        input  cmd_ready, rsp_valid, rsp_error, rsp_code, rsp_values, depth
    );
endinterface

interface wasm_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              memory_read_en;
    logic              memory_write_en;
    logic              memory_ready;

    modport master (
        output addr, data_in, memory_read_en, memory_write_en,
        input  data_out, memory_ready
    );

    modport slave (
        input  addr, data_in, memory_read_en, memory_write_en,
        output data_out, memory_ready
    );
endinterface

// File: rtl/wasm_mem_port.sv
// Single-byte read/write handshake engine: enable held until ready,
// next request only after ready has dropped again.
module wasm_mem_port
    import wasm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic              rdy_o,
    output logic              done_o,
    output logic [7:0]        rdata_o,
    wasm_mem_if.master        mem
);

    port_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= P_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            P_IDLE: if (req_i) state_d = P_BUSY;
            P_BUSY: if (mem.memory_ready) state_d = P_DROP;
            P_DROP: if (!mem.memory_ready) state_d = req_i ? P_BUSY : P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    always_comb begin
        rdy_o   = (state_q == P_IDLE) ||
                  (state_q == P_DROP && !mem.memory_ready);
        done_o  = (state_q == P_BUSY) && mem.memory_ready;
        rdata_o = mem.data_out;
        mem.memory_read_en  = (state_q == P_BUSY) && !we_q;
        mem.memory_write_en = (state_q == P_BUSY) && we_q;
        mem.addr    = addr_q;
        mem.data_in = wdata_q;
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (rdy_o && req_i) begin
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: rtl/wasm_operand_stack.sv
// Operand-stack engine: multi-byte little-endian slots in byte memory,
// push/pop/peek/drop with overflow, underflow and bad-count detection.
module wasm_operand_stack
    import wasm_pkg::*;
#(
    parameter int VALUE_W = 64,
    parameter int DEPTH   = 64,
    parameter int MAX_POP = 2,
    parameter int ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] STACK_BASE = 32'h0000_0100
) (
    input  logic       clk,
    input  logic       rst_n,
    wasm_stk_if.slave  stk,
    wasm_mem_if.master mem
);

    localparam int SLOT_BYTES = VALUE_W / 8;
    localparam int CW = $clog2(MAX_POP + 1);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(SLOT_BYTES + 1);
    localparam int RW = MAX_POP * VALUE_W;

    stk_state_e         state_q, state_d;
    stk_op_e            op_q, op_d;
    stk_code_e          code_q, code_d, chk_code;
    logic [CW-1:0]      cnt_q, cnt_d, idx_q, idx_d;
    logic               wide_q, wide_d;
    logic [VALUE_W-1:0] val_q, val_d;
    logic [DW-1:0]      depth_q, depth_d, slot;
    logic [BW-1:0]      byte_q, byte_d, last_byte;
    logic [RW-1:0]      buf_q, buf_d, rsp_q, rsp_d;
    logic               mreq, mwe, mrdy, mdone, byte_end, slot_end;
    logic [ADDR_W-1:0]  maddr;
    logic [7:0]         mwdata, mrdata;

    wasm_mem_port #(.ADDR_W(ADDR_W)) u_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (mreq),
        .we_i    (mwe),
        .addr_i  (maddr),
        .wdata_i (mwdata),
        .rdy_o   (mrdy),
        .done_o  (mdone),
        .rdata_o (mrdata),
        .mem     (mem)
    );

    // Push targets slot depth; reads walk slots depth-count .. depth-1.
    always_comb begin
        last_byte = wide_q ? BW'(SLOT_BYTES - 1) : BW'(3);
        byte_end  = (byte_q == last_byte);
        slot_end  = (op_q == STK_PUSH) || (idx_q == cnt_q - CW'(1));
        slot      = (op_q == STK_PUSH) ? depth_q
                  : depth_q - DW'(cnt_q) + DW'(idx_q);
        maddr     = STACK_BASE + ADDR_W'(slot) * ADDR_W'(SLOT_BYTES)
                  + ADDR_W'(byte_q);
        mwe       = (op_q == STK_PUSH);
        mwdata    = '0;
        for (int b = 0; b < SLOT_BYTES; b++)
            if (byte_q == BW'(b)) mwdata = val_q[b*8 +: 8];
    end

    always_comb begin
        chk_code = STK_OK;
        if (op_q == STK_PUSH) begin
            if (depth_q == DW'(DEPTH)) chk_code = STK_OVF;
        end else if (cnt_q == '0 || 32'(cnt_q) > MAX_POP) begin
            chk_code = STK_BADCNT;
        end else if (32'(cnt_q) > 32'(depth_q)) begin
            chk_code = STK_UDF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (stk.cmd_valid) state_d = S_CHECK;
            S_CHECK: begin
                if (chk_code != STK_OK || op_q == STK_DROP)
                    state_d = S_RESPOND;
                else if (op_q == STK_PUSH)
                    state_d = S_WR_BYTE;
                else
                    state_d = S_RD_BYTE;
            end
            S_WR_BYTE, S_RD_BYTE: if (mrdy) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (mdone) begin
                    if (byte_end && slot_end)  state_d = S_RESPOND;
                    else if (op_q == STK_PUSH) state_d = S_WR_BYTE;
                    else                       state_d = S_RD_BYTE;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stk.cmd_ready  = (state_q == S_IDLE);
        stk.rsp_valid  = (state_q == S_RESPOND);
        stk.rsp_error  = (state_q == S_RESPOND) && (code_q != STK_OK);
        stk.rsp_code   = code_q;
        stk.rsp_values = rsp_q;
        stk.depth      = depth_q;
        mreq = (state_q == S_WR_BYTE) || (state_q == S_RD_BYTE);
    end

    always_comb begin
        op_d    = op_q;
        cnt_d   = cnt_q;
        wide_d  = wide_q;
        val_d   = val_q;
        code_d  = code_q;
        depth_d = depth_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        buf_d   = buf_q;
        rsp_d   = rsp_q;
        if (state_q == S_IDLE && stk.cmd_valid) begin
            op_d   = stk_op_e'(stk.cmd_op);
            cnt_d  = stk.cmd_count;
            wide_d = stk.cmd_wide;
            val_d  = stk.cmd_value;
        end
        if (state_q == S_CHECK) begin
            code_d = chk_code;
            idx_d  = '0;
            byte_d = '0;
            buf_d  = '0;
            if (chk_code == STK_OK && op_q == STK_DROP)
                depth_d = depth_q - DW'(cnt_q);
        end
        // Reads land in a scratch buffer; rsp_values only moves on success.
        if (state_q == S_WAIT_IDLE && mdone) begin
            if (op_q != STK_PUSH)
                for (int i = 0; i < MAX_POP; i++)
                    for (int b = 0; b < SLOT_BYTES; b++)
                        if (idx_q == CW'(i) && byte_q == BW'(b))
                            buf_d[i*VALUE_W + b*8 +: 8] = mrdata;
            byte_d = byte_q + BW'(1);
            if (byte_end) begin
                byte_d = '0;
                idx_d  = idx_q + CW'(1);
                if (slot_end) begin
                    unique case (op_q)
                        STK_PUSH: depth_d = depth_q + DW'(1);
                        STK_POP: begin
                            depth_d = depth_q - DW'(cnt_q);
                            rsp_d   = buf_d;
                        end
                        STK_PEEK: rsp_d = buf_d;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= STK_PUSH;
            cnt_q   <= '0;
            wide_q  <= 1'b0;
            val_q   <= '0;
            code_q  <= STK_OK;
            depth_q <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            buf_q   <= '0;
            rsp_q   <= '0;
        end else begin
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            wide_q  <= wide_d;
            val_q   <= val_d;
            code_q  <= code_d;
            depth_q <= depth_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            buf_q   <= buf_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule
